// File: rtl/sdram_loader.sv
// Framed host byte stream -> sequential Avalon-MM byte writes into SDRAM.
// Frame layout: start word F00BF00B, TOTAL payload bytes, stop word DEADF00B.
`timescale 1ns/1ps
module sdram_loader #(
   parameter int MASTER_ADDRESSWIDTH = 28,
   parameter int DATAWIDTH = 8,
   parameter logic [MASTER_ADDRESSWIDTH-1:0] BASE_ADDR = 28'h8000000,
   parameter int IMSIZE = 128,
   parameter int L0SIZE = 2048,
   parameter int L1SIZE = 256,
   parameter int L2SIZE = 160
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [7:0]                     in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           abort,
   output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
   output logic [DATAWIDTH-1:0]           master_writedata,
   output logic                           master_write,
   output logic                           master_read,
   input  logic                           master_waitrequest,
   output logic                           data_valid,
   output logic                           load_error,
   output logic                           busy,
   output logic [11:0]                    bytes_written,
   output logic [1:0]                     fsm_state
);

   localparam int          TOTAL      = IMSIZE + L0SIZE + L1SIZE + L2SIZE;
   localparam logic [11:0] TOTAL_C    = 12'(TOTAL);
   localparam logic [31:0] START_WORD = 32'hF00BF00B;
   localparam logic [31:0] STOP_WORD  = 32'hDEADF00B;

   typedef enum logic [1:0] {
      S_HUNT    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_TRAILER = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] sr;
   logic [11:0] accepted;
   logic [1:0]  tcnt;
   logic        abort_req;
   logic        live;

   logic        ready_c;
   logic        in_frame;
   logic        stop_in;
   logic        take;
   logic        wr_done;
   logic [31:0] sr_next;

   // Handshakes: a byte moves when in_valid & in_ready on a rising edge; an Avalon
   // write retires when master_write & !master_waitrequest. master_write is the
   // pending flag of the one-deep write register.
   always_comb begin
      in_frame = (state == S_PAYLOAD) || (state == S_TRAILER);
      stop_in  = in_frame && (abort || abort_req);
      ready_c  = 1'b0;
      if (live && !stop_in) begin
         case (state)
            S_HUNT, S_TRAILER: ready_c = 1'b1;
            S_PAYLOAD:         ready_c = (!master_write || !master_waitrequest) &&
                                         (accepted < TOTAL_C);
            default:           ready_c = 1'b0;
         endcase
      end
   end

   assign in_ready    = ready_c;
   assign take        = in_valid & ready_c;
   assign wr_done     = master_write & ~master_waitrequest;
   assign sr_next     = {sr[23:0], in_data};
   assign busy        = in_frame | master_write;
   assign master_read = 1'b0;
   assign fsm_state   = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_HUNT;
         sr               <= '0;
         accepted         <= '0;
         tcnt             <= '0;
         abort_req        <= 1'b0;
         live             <= 1'b0;
         master_address   <= BASE_ADDR;
         master_writedata <= '0;
         master_write     <= 1'b0;
         data_valid       <= 1'b0;
         load_error       <= 1'b0;
         bytes_written    <= '0;
      end else begin
         live <= 1'b1;
         if (wr_done) begin
            master_address <= master_address + 1'b1;
            bytes_written  <= bytes_written + 12'd1;
            master_write   <= 1'b0;
         end
         case (state)
            S_HUNT: begin
               if (take) begin
                  sr <= sr_next;
                  if (sr_next == START_WORD) begin
                     state          <= S_PAYLOAD;
                     master_address <= BASE_ADDR;
                     bytes_written  <= '0;
                     accepted       <= '0;
                     data_valid     <= 1'b0;
                     load_error     <= 1'b0;
                     abort_req      <= 1'b0;
                  end
               end
            end
            S_PAYLOAD: begin
               // A byte loaded on the retiring cycle keeps master_write high.
               if (take) begin
                  master_writedata <= DATAWIDTH'(in_data);
                  master_write     <= 1'b1;
                  accepted         <= accepted + 12'd1;
               end
               if (stop_in) begin
                  if (!master_write || wr_done) begin
                     state      <= S_HUNT;
                     load_error <= 1'b1;
                     data_valid <= 1'b0;
                     abort_req  <= 1'b0;
                  end else begin
                     abort_req <= 1'b1;
                  end
               end else if (!master_write && bytes_written == TOTAL_C) begin
                  state <= S_TRAILER;
                  sr    <= '0;
                  tcnt  <= '0;
               end
            end
            S_TRAILER: begin
               if (stop_in) begin
                  state      <= S_HUNT;
                  load_error <= 1'b1;
                  data_valid <= 1'b0;
                  abort_req  <= 1'b0;
               end else if (take) begin
                  sr   <= sr_next;
                  tcnt <= tcnt + 2'd1;
                  if (tcnt == 2'd3) begin
                     if (sr_next == STOP_WORD) begin
                        state      <= S_DONE;
                        data_valid <= 1'b1;
                     end else begin
                        state      <= S_HUNT;
                        load_error <= 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               data_valid <= 1'b1;
               state      <= S_HUNT;
            end
            default: state <= S_HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_loader.sv
// Randomized frame-level bench for sdram_loader: expected SDRAM writes are queued
// as payload bytes are accepted and retired by an independent write monitor.
`timescale 1ns/1ps
module tb_sdram_loader;

   localparam int          TOTAL     = 2592;
   localparam logic [27:0] BASE      = 28'h8000000;
   localparam logic [31:0] GOOD_STOP = 32'hDEADF00B;
   localparam logic [1:0]  ST_HUNT   = 2'd0;
   localparam logic [1:0]  ST_PAYLD  = 2'd1;

   logic        clk;
   logic        reset_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        abort;
   logic [27:0] master_address;
   logic [7:0]  master_writedata;
   logic        master_write;
   logic        master_read;
   logic        master_waitrequest;
   logic        data_valid;
   logic        load_error;
   logic        busy;
   logic [11:0] bytes_written;
   logic [1:0]  fsm_state;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int wr_mode = 0;
   int wr_count = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   logic [35:0] exp_q[$];

   sdram_loader dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .in_data            (in_data),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .abort              (abort),
      .master_address     (master_address),
      .master_writedata   (master_writedata),
      .master_write       (master_write),
      .master_read        (master_read),
      .master_waitrequest (master_waitrequest),
      .data_valid         (data_valid),
      .load_error         (load_error),
      .busy               (busy),
      .bytes_written      (bytes_written),
      .fsm_state          (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #(5_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // slave stall pattern: 0 never, 1 three of four cycles, 2 random, 3 always
   initial begin
      master_waitrequest = 1'b0;
      forever begin
         @(negedge clk);
         case (wr_mode)
            0:       master_waitrequest = 1'b0;
            1:       master_waitrequest = (cyc % 4) != 0;
            2:       master_waitrequest = 1'($urandom_range(0, 1));
            default: master_waitrequest = 1'b1;
         endcase
      end
   end

   // write monitor: stable-while-stalled check and scoreboard pop on retire
   initial begin
      logic        prev_stall;
      logic [27:0] prev_addr;
      logic [7:0]  prev_data;
      logic [35:0] e;
      prev_stall = 1'b0;
      prev_addr  = '0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         #2;
         if (reset_n) begin
            if (prev_stall) begin
               check("hold_write", master_write, 1);
               check("hold_addr", master_address, prev_addr);
               check("hold_data", master_writedata, prev_data);
            end
            if (master_write && !master_waitrequest) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_write actual=%0h/%0h required=no write",
                           master_address, master_writedata);
               end else begin
                  e = exp_q.pop_front();
                  check("write_addr_data", {master_address, master_writedata}, e);
               end
               wr_count++;
               if (wr_count == 1) first_cyc = cyc;
               last_cyc = cyc;
            end
            prev_stall = master_write && master_waitrequest;
            prev_addr  = master_address;
            prev_data  = master_writedata;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b, output bit acc);
      acc = 1'b0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      for (int t = 0; t < 300; t++) begin
         #1;
         acc = in_ready;
         @(posedge clk);
         if (acc) break;
         @(negedge clk);
      end
      if (!acc) begin
         vectors++;
         miscompares++;
         $display("FAIL byte_accept_timeout actual=not accepted required=accepted byte=%0h", b);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic start_frame(input bit overlap);
      bit acc;
      int n;
      logic [31:0] sw;
      sw = 32'hF00BF00B;
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 239)), acc);
      if (overlap) send_byte(8'hF0, acc);
      for (int k = 3; k >= 0; k--) send_byte(sw[8*k +: 8], acc);
      #1;
      check("start_state", fsm_state, ST_PAYLD);
      check("start_busy", busy, 1);
      check("start_data_valid", data_valid, 0);
      check("start_load_error", load_error, 0);
      check("start_count", bytes_written, 0);
      check("start_addr", master_address, BASE);
      wr_count = 0;
   endtask

   task automatic send_payload(input int pat, input int nbytes, input bit gaps);
      bit acc;
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         b = (pat == 0) ? 8'(i) : 8'($urandom);
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
         send_byte(b, acc);
         if (acc) exp_q.push_back({BASE + 28'(i), b});
      end
   endtask

   task automatic finish_frame(input logic [31:0] stop);
      bit acc;
      bit good;
      good = (stop == GOOD_STOP);
      for (int k = 3; k >= 0; k--) send_byte(stop[8*k +: 8], acc);
      idle(4);
      #1;
      check("end_data_valid", data_valid, good);
      check("end_load_error", load_error, !good);
      check("end_state", fsm_state, ST_HUNT);
      check("end_count", bytes_written, TOTAL);
      check("end_busy", busy, 0);
      check("end_queue_empty", exp_q.size(), 0);
      check("end_hunt_ready", in_ready, 1);
   endtask

   initial begin
      bit acc;
      reset_n  = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      abort    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_write", master_write, 0);
      check("rst_read", master_read, 0);
      check("rst_addr", master_address, BASE);
      check("rst_wdata", master_writedata, 0);
      check("rst_ready", in_ready, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_load_error", load_error, 0);
      check("rst_busy", busy, 0);
      check("rst_count", bytes_written, 0);
      check("rst_state", fsm_state, ST_HUNT);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_ready", in_ready, 1);

      // ramp payload at full rate
      wr_mode = 0;
      start_frame(1'b0);
      send_payload(0, TOTAL, 1'b0);
      finish_frame(GOOD_STOP);
      check("rate_write_count", wr_count, TOTAL);
      check("rate_one_per_clk", last_cyc - first_cyc, TOTAL - 1);

      // same frame with slave stalled three cycles out of four
      wr_mode = 1;
      start_frame(1'b0);
      send_payload(0, TOTAL, 1'b0);
      finish_frame(GOOD_STOP);
      check("stall_write_count", wr_count, TOTAL);

      // overlapping start word, random data, random stalls and gaps
      wr_mode = 2;
      start_frame(1'b1);
      send_payload(1, TOTAL, 1'b1);
      finish_frame(GOOD_STOP);

      // bad stop word, then a clean frame
      wr_mode = 0;
      start_frame(1'b0);
      send_payload(1, TOTAL, 1'b0);
      finish_frame(32'hDEADF00C);
      start_frame(1'b0);
      send_payload(1, TOTAL, 1'b1);
      finish_frame(GOOD_STOP);

      // abort with byte 100 pending behind a stalled slave
      wr_mode = 0;
      start_frame(1'b0);
      send_payload(1, 101, 1'b0);
      wr_mode = 3;
      @(negedge clk);
      in_valid = 1'b0;
      abort    = 1'b1;
      #1;
      check("abort_ready_now", in_ready, 0);
      @(negedge clk);
      abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("abort_hold_ready", in_ready, 0);
         check("abort_hold_busy", busy, 1);
         check("abort_hold_addr", master_address, BASE + 28'd100);
         @(negedge clk);
      end
      @(posedge clk);
      wr_mode = 0;
      repeat (4) @(negedge clk);
      #1;
      check("abort_state", fsm_state, ST_HUNT);
      check("abort_load_error", load_error, 1);
      check("abort_data_valid", data_valid, 0);
      check("abort_count", bytes_written, 101);
      check("abort_queue_empty", exp_q.size(), 0);
      check("abort_busy", busy, 0);
      for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 239)), acc);
      idle(3);

      // reset in the middle of a payload
      start_frame(1'b0);
      send_payload(1, 51, 1'b0);
      @(negedge clk);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midrst_write", master_write, 0);
      check("midrst_addr", master_address, BASE);
      check("midrst_wdata", master_writedata, 0);
      check("midrst_busy", busy, 0);
      check("midrst_count", bytes_written, 0);
      check("midrst_ready", in_ready, 0);
      check("midrst_state", fsm_state, ST_HUNT);
      check("midrst_data_valid", data_valid, 0);
      check("midrst_load_error", load_error, 0);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      wr_mode = 2;
      start_frame(1'b1);
      send_payload(1, TOTAL, 1'b1);
      finish_frame(GOOD_STOP);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
